// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Shares a single APB master port between two requesters (e.g. the CPU-side
// register path and the UART command path). Requesters are arbitrated
// round-robin. Each granted transfer runs through the APB SETUP and ACCESS
// phases. Read data and PSLVERR are returned to the owner with a one-cycle
// done pulse. A transfer stalled by PREADY for TIMEOUT ACCESS cycles is
// aborted with an error.
//
// Parameters
//   ADDR_W   width of PADDR / reqN_addr
//   DATA_W   width of PWDATA / PRDATA / requester data (strobes are DATA_W/8)
//   TIMEOUT  max ACCESS cycles with PREADY low before abort; 0 = no timeout
//
// Ports
//   PCLK, PRESETn                      clock, asynchronous active-low reset
//   reqN_valid/addr/write/wdata/strb   requester N request (held until done)
//   reqN_done/rdata/err                requester N completion pulse and result
//   busy                               a transfer is in progress
//   PSEL/PENABLE/PADDR/PWRITE/PSTRB/PWDATA   APB master outputs
//   PRDATA/PREADY/PSLVERR                    APB slave responses
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module apb_master_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  req0_valid,
   input  logic [ADDR_W-1:0]     req0_addr,
   input  logic                  req0_write,
   input  logic [DATA_W-1:0]     req0_wdata,
   input  logic [DATA_W/8-1:0]   req0_strb,
   output logic                  req0_done,
   output logic [DATA_W-1:0]     req0_rdata,
   output logic                  req0_err,
   input  logic                  req1_valid,
   input  logic [ADDR_W-1:0]     req1_addr,
   input  logic                  req1_write,
   input  logic [DATA_W-1:0]     req1_wdata,
   input  logic [DATA_W/8-1:0]   req1_strb,
   output logic                  req1_done,
   output logic [DATA_W-1:0]     req1_rdata,
   output logic                  req1_err,
   output logic                  busy,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [ADDR_W-1:0]     PADDR,
   output logic                  PWRITE,
   output logic [DATA_W/8-1:0]   PSTRB,
   output logic [DATA_W-1:0]     PWDATA,
   input  logic [DATA_W-1:0]     PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int STRB_W = DATA_W / 8;
   // Counter only needs to reach TIMEOUT-1: the abort fires on the
   // TIMEOUT-th stalled ACCESS cycle.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t            state;
   logic              last_gnt;   // also identifies the owner of the active transfer
   logic [CNT_W-1:0]  wait_cnt;

   logic              elig0, elig1, gnt_any, gnt_sel;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_write;
   logic [DATA_W-1:0] sel_wdata;
   logic [STRB_W-1:0] sel_strb;
   logic              fin_ok, fin_to;
   logic [DATA_W-1:0] fin_rdata;
   logic              fin_err;

   // A requester showing its done pulse is masked so its finished request
   // cannot be re-granted in the same cycle.
   assign elig0   = req0_valid & ~req0_done;
   assign elig1   = req1_valid & ~req1_done;
   assign gnt_any = elig0 | elig1;

   always_comb begin
      gnt_sel = elig1;
      if (elig0 && elig1) begin
         gnt_sel = ~last_gnt;
      end
   end

   assign sel_addr  = gnt_sel ? req1_addr  : req0_addr;
   assign sel_write = gnt_sel ? req1_write : req0_write;
   assign sel_wdata = gnt_sel ? req1_wdata : req0_wdata;
   assign sel_strb  = gnt_sel ? req1_strb  : req0_strb;

   always_comb begin
      fin_ok    = (state == ST_ACCESS) && PREADY;
      fin_to    = (state == ST_ACCESS) && !PREADY && (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
      fin_rdata = (fin_ok && !PWRITE) ? PRDATA : '0;
      fin_err   = fin_ok ? PSLVERR : 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= ST_IDLE;
         last_gnt   <= 1'b1;
         wait_cnt   <= '0;
         busy       <= 1'b0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PADDR      <= '0;
         PWRITE     <= 1'b0;
         PSTRB      <= '0;
         PWDATA     <= '0;
         req0_done  <= 1'b0;
         req0_rdata <= '0;
         req0_err   <= 1'b0;
         req1_done  <= 1'b0;
         req1_rdata <= '0;
         req1_err   <= 1'b0;
      end else begin
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         unique case (state)
            // IDLE -> SETUP: latch the winner's request onto the bus
            ST_IDLE: begin
               if (gnt_any) begin
                  PSEL     <= 1'b1;
                  PENABLE  <= 1'b0;
                  PADDR    <= sel_addr;
                  PWRITE   <= sel_write;
                  PWDATA   <= sel_write ? sel_wdata : '0;
                  PSTRB    <= sel_write ? sel_strb  : '0;
                  last_gnt <= gnt_sel;
                  busy     <= 1'b1;
                  state    <= ST_SETUP;
               end
            end
            // SETUP -> ACCESS
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
            end
            // ACCESS -> IDLE on PREADY or timeout; result goes to the owner
            ST_ACCESS: begin
               if (fin_ok || fin_to) begin
                  PSEL     <= 1'b0;
                  PENABLE  <= 1'b0;
                  busy     <= 1'b0;
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
                  if (last_gnt) begin
                     req1_done  <= 1'b1;
                     req1_rdata <= fin_rdata;
                     req1_err   <= fin_err;
                  end else begin
                     req0_done  <= 1'b1;
                     req0_rdata <= fin_rdata;
                     req0_err   <= fin_err;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
`timescale 1ns/1ps
module tb_apb_master_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        v  [2];
   logic [31:0] a  [2];
   logic        w  [2];
   logic [31:0] wd [2];
   logic [3:0]  st [2];
   logic        req0_done, req1_done, req0_err, req1_err, busy;
   logic [31:0] req0_rdata, req1_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [3:0]  PSTRB;

   int n_tests = 0;
   int n_fail  = 0;

   apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req0_valid(v[0]), .req0_addr(a[0]), .req0_write(w[0]), .req0_wdata(wd[0]),
      .req0_strb(st[0]), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(v[1]), .req1_addr(a[1]), .req1_write(w[1]), .req1_wdata(wd[1]),
      .req1_strb(st[1]), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
      .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
      .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // One outstanding transfer at most; outputs follow from "is a transfer
   // active, has it entered ACCESS, who owns it, how long has it stalled".
   bit          m_act, m_acc, m_last;
   int          m_own, m_wait;
   logic [31:0] m_addr, m_wdata;
   bit          m_write;
   logic [3:0]  m_strb;
   bit          m_done [2];
   logic [31:0] m_rdata [2];
   bit          m_err [2];
   bit          nd [2];
   bit          e0, e1;
   int          g;

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         m_act = 0; m_acc = 0; m_last = 1; m_own = 0; m_wait = 0;
         m_addr = 0; m_wdata = 0; m_write = 0; m_strb = 0;
         for (int r = 0; r < 2; r++) begin
            m_done[r] = 0; m_rdata[r] = 0; m_err[r] = 0;
         end
      end else begin
         nd[0] = 0; nd[1] = 0;
         if (!m_act) begin
            e0 = v[0] && !m_done[0];
            e1 = v[1] && !m_done[1];
            if (e0 || e1) begin
               if (e0 && e1) g = m_last ? 0 : 1;
               else          g = e1 ? 1 : 0;
               m_act = 1; m_acc = 0; m_own = g; m_wait = 0; m_last = (g == 1);
               m_addr  = a[g];
               m_write = w[g];
               m_wdata = w[g] ? wd[g] : 32'h0;
               m_strb  = w[g] ? st[g] : 4'h0;
            end
         end else if (!m_acc) begin
            m_acc = 1;
         end else if (PREADY) begin
            nd[m_own] = 1;
            m_rdata[m_own] = m_write ? 32'h0 : PRDATA;
            m_err[m_own] = PSLVERR;
            m_act = 0; m_acc = 0;
         end else begin
            m_wait++;
            if (TO != 0 && m_wait == TO) begin
               nd[m_own] = 1;
               m_rdata[m_own] = 32'h0;
               m_err[m_own] = 1;
               m_act = 0; m_acc = 0;
            end
         end
         m_done[0] = nd[0];
         m_done[1] = nd[1];
      end
   end

   // ---------------- per-cycle comparison against the model ----------------
   always @(negedge PCLK) begin
      if (PRESETn === 1'b1) begin
         check("psel",    PSEL,    m_act);
         check("penable", PENABLE, m_act && m_acc);
         check("busy",    busy,    m_act);
         check("done0",   req0_done,  m_done[0]);
         check("done1",   req1_done,  m_done[1]);
         check("rdata0",  req0_rdata, m_rdata[0]);
         check("rdata1",  req1_rdata, m_rdata[1]);
         check("err0",    req0_err,   m_err[0]);
         check("err1",    req1_err,   m_err[1]);
         if (m_act) begin
            check("paddr",  PADDR,  m_addr);
            check("pwrite", PWRITE, m_write);
            check("pwdata", PWDATA, m_wdata);
            check("pstrb",  PSTRB,  m_strb);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_req(input int r, input logic wr, input logic [31:0] ad,
                          input logic [31:0] dat, input logic [3:0] sb);
      a[r] = ad; w[r] = wr; wd[r] = dat; st[r] = sb; v[r] = 1'b1;
   endtask

   task automatic rand_req(input int r);
      set_req(r, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)));
   endtask

   task automatic wait_done(input int r, input int limit, input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         step();
         seen = (r == 0) ? req0_done : req1_done;
      end
      check(name, seen, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cnt, sel_cnt, ng, gap, stall;
      bit seen;
      logic [3:0] gr [4];

      PRESETn = 1'b0;
      for (int r = 0; r < 2; r++) begin
         v[r] = 0; a[r] = 0; w[r] = 0; wd[r] = 0; st[r] = 0;
      end
      PREADY = 0; PSLVERR = 0; PRDATA = 0;
      repeat (3) step();
      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_busy", busy, 0);
      check("rst_done0", req0_done, 0);
      check("rst_done1", req1_done, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_rdata1", req1_rdata, 0);
      PRESETn = 1'b1;
      step();

      // Write from req0 with a ready slave
      PREADY = 1;
      set_req(0, 1'b1, 32'h0, 32'hA301200F, 4'hF);
      step();
      check("wr_psel", PSEL, 1);
      check("wr_penable_setup", PENABLE, 0);
      check("wr_paddr", PADDR, 32'h0);
      check("wr_pwdata", PWDATA, 32'hA301200F);
      check("wr_pstrb", PSTRB, 4'hF);
      step();
      check("wr_penable_access", PENABLE, 1);
      check("wr_pwdata_stable", PWDATA, 32'hA301200F);
      step();
      check("wr_done0", req0_done, 1);
      check("wr_err0", req0_err, 0);
      check("wr_rdata0", req0_rdata, 0);
      check("wr_psel_low", PSEL, 0);
      v[0] = 0;
      step();
      check("wr_done0_pulse", req0_done, 0);

      // Read from req1 with three wait states
      PREADY = 0;
      set_req(1, 1'b0, 32'h3, 32'hDEADBEEF, 4'hF);
      step();
      check("ws_pstrb_read", PSTRB, 0);
      check("ws_pwdata_read", PWDATA, 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("ws_penable_held", PENABLE, 1);
         check("ws_paddr_held", PADDR, 32'h3);
         if (k == 4) begin
            PREADY = 1;
            PRDATA = 32'h0070240F;
         end
      end
      step();
      check("ws_done1", req1_done, 1);
      check("ws_rdata1", req1_rdata, 32'h0070240F);
      check("ws_model_rdata1", m_rdata[1], 32'h0070240F);
      v[1] = 0;
      PRDATA = $urandom;
      step();
      check("ws_done1_pulse", req1_done, 0);
      check("ws_rdata1_hold", req1_rdata, 32'h0070240F);

      // Slave error on a req0 write
      PSLVERR = 1;
      set_req(0, 1'b1, 32'h8, 32'h55, 4'h3);
      wait_done(0, 10, "err_done_seen");
      check("err_err0", req0_err, 1);
      check("err_model_err0", m_err[0], 1);
      check("err_err1_unaffected", req1_err, 0);
      check("err_rdata1_unaffected", req1_rdata, 32'h0070240F);
      v[0] = 0;
      PSLVERR = 0;
      step();

      // Timeout: slave never ready
      PREADY = 0;
      PRDATA = 32'hFFFFFFFF;
      set_req(0, 1'b0, 32'h4, 32'h0, 4'h0);
      en_cnt = 0; sel_cnt = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (req0_done) seen = 1;
         else begin
            if (PENABLE) en_cnt++;
            if (PSEL) sel_cnt++;
         end
      end
      check("to_done_seen", seen, 1);
      check("to_penable_cycles", en_cnt, 16);
      check("to_psel_cycles", sel_cnt, 17);
      check("to_err0", req0_err, 1);
      check("to_rdata0", req0_rdata, 0);
      v[0] = 0;
      PREADY = 1;
      set_req(1, 1'b1, 32'hC, 32'h1234, 4'hF);
      wait_done(1, 10, "to_next_done_seen");
      check("to_next_err1", req1_err, 0);
      v[1] = 0;
      step();

      // Reset asserted during ACCESS
      PREADY = 0;
      set_req(0, 1'b1, 32'h40, 32'hCAFE, 4'hF);
      repeat (3) step();
      #2 PRESETn = 1'b0;
      #1;
      check("rmid_psel", PSEL, 0);
      check("rmid_penable", PENABLE, 0);
      check("rmid_busy", busy, 0);
      check("rmid_paddr", PADDR, 0);
      check("rmid_pwdata", PWDATA, 0);
      check("rmid_pstrb", PSTRB, 0);
      v[0] = 0;
      step();
      step();
      check("rmid_no_done0", req0_done, 0);
      PRESETn = 1'b1;

      // Tie right after reset, then both held continuously for 4 transfers
      PREADY = 1;
      set_req(0, 1'b1, 32'h100, 32'h11, 4'hF);
      set_req(1, 1'b0, 32'h200, 32'h22, 4'hF);
      ng = 0; gap = 0;
      for (int i = 0; i < 60 && ng < 4; i++) begin
         step();
         if (m_done[0]) a[0] = a[0] + 1;
         if (m_done[1]) a[1] = a[1] + 1;
         if (PSEL && !PENABLE) begin
            gr[ng] = PADDR[11:8];
            if (ng > 0) check("rr_psel_gap", gap, 1);
            ng++;
            gap = 0;
            if (ng == 4) begin
               v[0] = 0; v[1] = 0;
            end
         end else if (!PSEL) begin
            gap++;
         end
      end
      check("rr_grants", ng, 4);
      check("rr_g0", gr[0], 4'h1);
      check("rr_g1", gr[1], 4'h2);
      check("rr_g2", gr[2], 4'h1);
      check("rr_g3", gr[3], 4'h2);
      for (int i = 0; i < 10 && busy; i++) step();
      step();

      // Randomized traffic
      stall = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int r = 0; r < 2; r++) begin
            if (v[r]) begin
               if (m_done[r]) begin
                  if ($urandom_range(1) == 0) v[r] = 0;
                  else rand_req(r);
               end else if (!(m_act && m_own == r) && $urandom_range(19) == 0) begin
                  v[r] = 0;
               end
            end else if ($urandom_range(3) == 0) begin
               rand_req(r);
            end
         end
         if (stall > 0) begin
            stall--;
            PREADY = 0;
         end else if ($urandom_range(99) == 0) begin
            stall = 20;
            PREADY = 0;
         end else begin
            PREADY = ($urandom_range(9) < 6);
         end
         PSLVERR = ($urandom_range(7) == 0);
         PRDATA  = $urandom;
      end
      v[0] = 0; v[1] = 0;
      PREADY = 1;
      repeat (30) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
